// File: rtl/uart_tx_sequencer_if.sv
// Byte-wide link between the transmit sequencer and the UART TX core.
// tx_start is a one-cycle request with tx_data valid; it is only raised while tx_busy is low, and the UART acknowledges by raising tx_busy until the byte is out.
interface uart_tx_sequencer_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;

    modport master (output tx_data, output tx_start, input tx_busy);
    modport slave  (input tx_data, input tx_start, output tx_busy);
endinterface

// File: rtl/uart_tx_sequencer.sv
// Sends NUM_STEPS words of DATA_W bits, LSB byte first, through a byte-wide UART.
// One press sends one step (manual) or the whole sequence (auto).
module uart_tx_sequencer #(
    parameter int NUM_STEPS = 3,
    parameter int DATA_W    = 16,
    parameter int ID_W      = $clog2(NUM_STEPS + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        pb,
    input  logic                        auto_mode,
    input  logic [NUM_STEPS*DATA_W-1:0] step_data,
    uart_tx_sequencer_if.master         tx,
    output logic [ID_W-1:0]             step_id,
    output logic                        seq_done,
    output logic [2:0]                  dbg_state_o
);
    localparam int BYTES  = (DATA_W + 7) / 8;
    localparam int SH_W   = BYTES * 8;
    localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SEND    = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
        PAUSE   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              pb_q;
    logic              auto_q, auto_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic [SH_W-1:0]   shift_q, shift_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [ID_W-1:0]   step_id_q, step_id_d;
    logic              seq_done_q, seq_done_d;
    logic              tx_start_c;
    logic              press;
    logic [SH_W-1:0]   word_ext;

    assign press    = pb & ~pb_q;
    // Zero-extension pads the final byte when DATA_W is not a byte multiple.
    assign word_ext = SH_W'(step_data[int'(step_q)*DATA_W +: DATA_W]);

    always_comb begin
        state_d    = state_q;
        auto_d     = auto_q;
        step_d     = step_q;
        byte_d     = byte_q;
        shift_d    = shift_q;
        tx_data_d  = tx_data_q;
        step_id_d  = step_id_q;
        seq_done_d = 1'b0;
        tx_start_c = 1'b0;
        case (state_q)
            IDLE: if (press) begin
                auto_d  = auto_mode;
                step_d  = '0;
                state_d = LOAD;
            end
            LOAD: begin
                shift_d   = word_ext;
                tx_data_d = word_ext[7:0];
                byte_d    = '0;
                step_id_d = ID_W'(step_q) + ID_W'(1);
                state_d   = SEND;
            end
            SEND: if (!tx.tx_busy) begin
                tx_start_c = 1'b1;
                state_d    = WAIT_HI;
            end
            WAIT_HI: if (tx.tx_busy) state_d = WAIT_LO;
            WAIT_LO: if (!tx.tx_busy) begin
                if (byte_q != LAST_BYTE) begin
                    shift_d   = shift_q >> 8;
                    tx_data_d = shift_d[7:0];
                    byte_d    = byte_q + BYTE_W'(1);
                    state_d   = SEND;
                end else if (step_q == LAST_STEP) begin
                    seq_done_d = 1'b1;
                    step_id_d  = '0;
                    state_d    = IDLE;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                    state_d = auto_q ? LOAD : PAUSE;
                end
            end
            PAUSE: if (press) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            pb_q       <= 1'b0;
            auto_q     <= 1'b0;
            step_q     <= '0;
            byte_q     <= '0;
            shift_q    <= '0;
            tx_data_q  <= '0;
            step_id_q  <= '0;
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pb_q       <= pb;
            auto_q     <= auto_d;
            step_q     <= step_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            tx_data_q  <= tx_data_d;
            step_id_q  <= step_id_d;
            seq_done_q <= seq_done_d;
        end
    end

    // Gating with reset keeps a pending SEND from strobing the UART while reset is held.
    assign tx.tx_start  = tx_start_c & ~reset;
    assign tx.tx_data   = tx_data_q;
    assign step_id      = step_id_q;
    assign seq_done     = seq_done_q;
    assign dbg_state_o  = state_q;
endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
- Parametrised transmit sequencer for the UART link. It sends NUM_STEPS operand/control words, each DATA_W bits, as byte streams through a byte-wide UART transmitter.
- Two modes: in manual mode each push-button press sends one step; in auto mode one press sends all steps back-to-back.
- Sits between debounced board buttons/switches and the UART TX core. It drives the step indicator for the LEDs.

Parameters:
- NUM_STEPS, 3, number of words per sequence (>=1).
- DATA_W, 16, bits per word (>=1). BYTES = ceil(DATA_W/8).
- ID_W, $clog2(NUM_STEPS+1), width of step_id.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- pb  in  1  debounced push-button level; rising edge triggers.
- auto_mode  in  1  1 = send whole sequence per press; 0 = one step per press. Sampled at each accepted press.
- step_data  in  NUM_STEPS*DATA_W  word k (0-based) at bits [k*DATA_W +: DATA_W]. Captured when its step starts.
- tx_data  out  8  byte to UART.
- tx_start  out  1  one-cycle start strobe to UART.
- tx_busy  in  1  UART transmitting.
- step_id  out  ID_W  0 = idle/armed; k = step k (1-based) in progress or last completed in manual mode.
- seq_done  out  1  one-cycle pulse after last byte of last step completes.

Behaviour:
- Reset values: tx_data=0, tx_start=0, step_id=0, seq_done=0, state=IDLE, step/byte counters=0, pb_q=0.
- Reset mid-transfer aborts immediately; no further tx_start is issued. The UART finishes its current byte on its own.
- Press = pb & ~pb_q, where pb_q is pb registered. Presses are ignored in every state except IDLE and PAUSE.
- States:
  - IDLE: on press, latch auto_mode, step=0, go to LOAD.
  - LOAD: capture word[step] into shift register, byte=0, step_id=step+1, go to SEND. One cycle.
  - SEND: when tx_busy=0, assert tx_start for exactly this cycle. tx_data = low byte of shift register. Go to WAIT_HI. If tx_busy=1, hold in SEND with tx_start=0.
  - WAIT_HI: wait until tx_busy=1, then go to WAIT_LO. The UART must raise busy within 2 cycles of tx_start. No timeout.
  - WAIT_LO: when tx_busy=0:
    - If byte<BYTES-1: shift register right 8, byte++, go to SEND.
    - Else if step=NUM_STEPS-1: pulse seq_done, step_id=0, go to IDLE.
    - Else, auto mode: step++, go to LOAD.
    - Else, manual mode: step++, go to PAUSE.
  - PAUSE: step_id holds the completed step number. On press go to LOAD. Pressing in PAUSE does not re-sample auto_mode.
- Byte order: LSB byte first. The final byte is zero-padded in its upper bits when DATA_W is not a multiple of 8.
- tx_data is registered. It is stable from the tx_start cycle until the next SEND.
- Words are captured at LOAD, so step_data changes during transmission do not affect the bytes in flight.
- Latency: press detected at cycle n → LOAD at n+1 → tx_start at n+2 (tx_busy low).
- Simultaneous events:
  - Press in the same cycle that WAIT_LO exits to IDLE is ignored; only a later edge counts.
  - A held pb produces a single press.
- NUM_STEPS=1: every press sends one word and pulses seq_done; PAUSE is never entered.

Test Plan:
- Reset behaviour: reset asserted for 3 cycles mid-SEND, with a UART model whose busy lasts 10 cycles → all outputs zero. No tx_start for 20 cycles after reset deasserts with pb low.
- Auto mode, defaults: step_data = {16'h00C3, 16'h1234, 16'hABCD} (word0=ABCD), auto_mode=1, one pb pulse → bytes CD,AB,34,12,C3,00 in order. step_id goes 1,1,2,2,3,3. seq_done pulses once after byte 6 busy falls. step_id=0.
- Manual mode: auto_mode=0 → press1 sends CD,AB and holds step_id=1 in PAUSE. Press2 sends 34,12 with step_id=2. Press3 sends C3,00, then seq_done, step_id=0.
- Busy handshake: tx_busy already high when SEND entered → tx_start held low until busy falls. Exactly one tx_start per byte. Held pb for 100 cycles → only one sequence.
- Ignore presses / data capture: pb edges during WAIT_LO and WAIT_HI → ignored. step_data changes during transmission → transmitted bytes unchanged.
- Odd width, NUM_STEPS=2, DATA_W=12: words 12'hFFF, 12'h5A5 → bytes FF,0F,A5,05.
